// File: rtl/bscac7_pkg.sv
// Shared BSCAC7 definitions: bus geometry, bus state type and the reset bus state
// that both encoder and decoder start from.
package bscac7_pkg;

  localparam int BSCAC7_WIRES = 7;
  localparam int BSCAC7_STSVS = 6;

  // Index 0 is the DTSV, indices 1..6 are the STSV lanes.
  typedef logic [0:BSCAC7_WIRES-1] bscac7_bus_t;

  localparam bscac7_bus_t BSCAC7_BUS_RST = 7'b0;

endpackage

// File: rtl/bscac7_free_flag_calc.sv
// Combinational free-lane flags for one BSCAC7 transition prev -> cur.
// Same equations as the encoder, so either side can use it.
module bscac7_free_flag_calc
  import bscac7_pkg::*;
(
  input  bscac7_bus_t                prev,
  input  bscac7_bus_t                cur,
  output logic [1:BSCAC7_STSVS]      free_flag
);

  logic [0:BSCAC7_WIRES-1] x;
  logic [1:BSCAC7_STSVS]   p;

  always_comb begin
    x = ~(prev ^ cur);
    p = '0;
    for (int k = 1; k <= BSCAC7_STSVS; k++) begin
      p[k] = ~(prev[0] ^ prev[k]);
    end
  end

  // x[0] set means the DTSV held its level; lane 1 is then unconditionally free.
  always_comb begin
    free_flag = '1;
    if (x[0]) begin
      for (int k = 2; k <= BSCAC7_STSVS; k++) begin
        free_flag[k] = ~(prev[k] ^ prev[k-1]) | x[k-1];
      end
    end else begin
      free_flag[1] = p[1] | (~p[6] & ~p[2]) | (p[6] & p[2] & x[6] & x[2]);
      for (int k = 2; k <= BSCAC7_STSVS - 1; k++) begin
        free_flag[k] = p[k] | (~p[k-1] & ~p[k+1]) | (~p[k-1] & ~x[k-1])
                     | (p[k-1] & p[k+1] & x[k-1] & x[k+1]);
      end
      free_flag[6] = p[6] | (~p[5] & ~p[1]) | (~p[5] & ~x[5]) | (~p[1] & ~x[1])
                   | (p[5] & p[1] & x[5] & x[1]);
    end
  end

endmodule

// File: rtl/bscac7_lane_fifo.sv
// Single-bit lane FIFO; a push into a full FIFO is accepted only alongside a pop.
module bscac7_lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic empty,
  output logic full,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  // Head is forced low when empty so an idle word reads as all zeros.
  assign dout     = ~empty & mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/bscac7_dec_lane_unpack.sv
// BSCAC7 receive lane unpacker: pushes each free lane bit of a received bus
// state into its lane FIFO and emits a 7-bit word once every lane has a bit.
module bscac7_dec_lane_unpack
  import bscac7_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bus_valid,
  input  bscac7_bus_t              bus_state,
  output logic                     word_valid,
  input  logic                     word_ready,
  output bscac7_bus_t              word_data,
  output logic [1:BSCAC7_STSVS]    lane_free,
  output logic [0:BSCAC7_WIRES-1]  lane_full,
  output logic                     err_overflow,
  output logic                     err_protocol
);

  bscac7_bus_t               prev;
  logic [1:BSCAC7_STSVS]     free_flag;
  logic [0:BSCAC7_WIRES-1]   push_lane;
  logic [0:BSCAC7_WIRES-1]   fifo_empty;
  logic [0:BSCAC7_WIRES-1]   fifo_ovf;
  logic                      pop;
  logic                      proto_hit;

  bscac7_free_flag_calc u_free_flag_calc (
    .prev      (prev),
    .cur       (bus_state),
    .free_flag (free_flag)
  );

  // Lane 0 (DTSV) is always free.
  assign push_lane  = {bus_valid, {BSCAC7_STSVS{bus_valid}} & free_flag};
  assign word_valid = ~|fifo_empty;
  assign pop        = word_valid & word_ready;
  assign proto_hit  = bus_valid &
                      (|(~free_flag & (prev[1:BSCAC7_STSVS] ^ bus_state[1:BSCAC7_STSVS])));

  for (genvar i = 0; i < BSCAC7_WIRES; i++) begin : g_lane
    bscac7_lane_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_lane_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_lane[i]),
      .din      (bus_state[i]),
      .pop      (pop),
      .dout     (word_data[i]),
      .empty    (fifo_empty[i]),
      .full     (lane_full[i]),
      .overflow (fifo_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev         <= BSCAC7_BUS_RST;
      lane_free    <= '1;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      if (bus_valid) begin
        prev      <= bus_state;
        lane_free <= free_flag;
      end
      err_overflow <= err_overflow | (|fifo_ovf);
      err_protocol <= err_protocol | proto_hit;
    end
  end

endmodule

// File: doc/bscac7_dec_lane_unpack.md
# bscac7_dec_lane_unpack

Receive-side BSCAC7 lane unpacker. Each cycle it takes one received 7-wire bus state, made of the DTSV on wire 0 and STSVs on wires 1–6. It recomputes which STSV lanes the encoder left free, pushes each free lane's bit into a per-lane FIFO, and emits a 7-bit word once every lane holds a bit. It sits after the bus receiver and is the decode-side mirror of the encoder's FIFO read-control generation.

## Interface
- FIFO_DEPTH, 4: entries per lane FIFO; power of two, at least 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_valid  in  1  bus_state holds a new transmitted state this cycle.
- bus_state  in  [0:6]  received wire levels; [0] is the DTSV.
- word_valid  out  1  a complete word is available.
- word_ready  in  1  downstream accepts the word.
- word_data  out  [0:6]  head bit of each lane FIFO.
- lane_free  out  [1:6]  registered free flags of the last accepted bus state.
- lane_full  out  [0:6]  per-lane FIFO full; used for link-level flow control.
- err_overflow  out  1  sticky; a bit was pushed into a full lane.
- err_protocol  out  1  sticky; a locked lane changed level.

## Operation
- Reference state `prev[0:6]` is a register, reset to 0000000; this matches the encoder's reset state.
- On bus_valid, define:
  - `cur = bus_state`
  - `x_k = prev_k XNOR cur_k`
  - `p_k = prev_0 XNOR prev_k`
- Lane 0 is always free.
- Case 0 (x_0 = 1, DTSV unchanged):
  - f1 = 1
  - fk = (prev_k XNOR prev_{k-1}) | x_{k-1}, for k = 2..6
- Case 1 (x_0 = 0):
  - f1 = p1 | (~p6&~p2) | (p6&p2&x6&x2)
  - fk, k = 2..5 = pk | (~p_{k-1}&~p_{k+1}) | (~p_{k-1}&~x_{k-1}) | (p_{k-1}&p_{k+1}&x_{k-1}&x_{k+1})
  - f6 = p6 | (~p5&~p1) | (~p5&~x5) | (~p1&~x1) | (p5&p1&x5&x1)
- These are exactly the encoder equations, with the received state substituted for the encoder's candidate next state.
- Free lane k: push cur_k into FIFO k.
- Locked lane k (fk = 0):
  - no push.
  - If x_k = 0, set err_protocol.
- Every accepted beat updates `prev <= cur`, regardless of errors or overflow.
- Word output:
  - word_valid = all 7 FIFOs non-empty.
  - Pop all 7 FIFOs on word_valid & word_ready.
- FIFO full/overflow:
  - A push to a full lane with a simultaneous pop is accepted.
  - A push to a full lane without a pop is dropped and sets err_overflow; other lanes still push.
- Pop on empty cannot occur, because word_valid gates the pop.
- No bus_valid: prev and the FIFOs hold; popping continues.

## Timing
- Free flags are combinational in the bus_valid cycle T. At edge T+1:
  - pushes and prev update take effect;
  - lane_free updates.
- word_valid and word_data come from registered FIFO state. Earliest word_valid is cycle T+1 after the completing push, i.e. 1-cycle latency.
- Throughput: one bus beat and one word per cycle, sustained.
- Reset values:
  - prev = 0, lane_free = 111111
  - all FIFOs empty; word_valid = 0, word_data = 0000000
  - lane_full = 0, err_overflow = 0, err_protocol = 0
- rst mid-stream flushes all FIFOs and discards partial words in the same edge. A bus_valid asserted together with rst is ignored.
- Error flags clear only on rst.

## Structure
- Shared package `bscac7_pkg`:
  - BSCAC7_WIRES = 7, BSCAC7_STSVS = 6
  - bus state typedef
  - reset bus state constant 7'b0
- Sub-module `bscac7_free_flag_calc`: combinational prev/cur → f[1:6], holding the equations above. The encoder-side control logic may reuse it for checking.
- Lane FIFOs: 7 instances of one 1-bit FIFO with pointers and count.

## Test plan
- **Reset then first beat.** After reset, bus_state 1000000 (case 1, all p = 1 → all free) → lane_free = 111111; next cycle word_valid = 1, word_data = 1000000.
- **Case 0 locking.**
  - Beat 0100000: all free → word 0100000, popped.
  - Beat 0000000: x1 = 0 and prev2 ≠ prev1 → f2 = 0 → lane_free = 101111. Lane 2 gets no push, so word_valid stays 0.
  - Beat 0000000 again: f2 = 1 → word 0000000.
- **Protocol error.** Prev 0100000, beat 0010000: lane 2 locked but changed → err_protocol = 1 and stays 1; prev becomes 0010000.
- **Overflow.** FIFO_DEPTH = 4, word_ready = 0, five beats alternating 1000000/0000000 (all free) → lane_full = 1111111 after 4; fifth beat sets err_overflow. After word_ready = 1, four words 1000000, 0000000, 1000000, 0000000 come out.
- **Full with simultaneous pop.** FIFOs full, word_ready = 1 and bus_valid together → no overflow; occupancy stays 4.
- **Reset mid-stream.** 3 partial beats queued, then assert rst → word_valid = 0; next beat is evaluated against prev = 0000000.
